// File: rtl/fft_pkg.sv
// Shared constants and types for the 8-point FFT input path.
// Frame length, sample widths and the input buffer state encoding.
package fft_pkg;

    localparam int NPT = 8;
    localparam int SW  = 32;
    localparam int HW  = 16;
    localparam int IW  = $clog2(NPT);

    typedef logic [SW-1:0] smp_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } st_t;

endpackage

// File: rtl/fft8_in_buf_if.sv
// Serial complex-sample stream into the FFT input buffer.
// The source drives data/valid/sof; the buffer returns ready.
interface fft8_in_buf_if
    import fft_pkg::*;
();

    smp_t s_data;
    logic s_valid;
    logic s_sof;
    logic s_ready;

    modport master (
        output s_data,
        output s_valid,
        output s_sof,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_sof,
        output s_ready
    );

endinterface

// File: rtl/fft_scale3.sv
// Divides re and im of one complex word by 8 (arithmetic shift,
// rounding toward -inf) to leave headroom for 3 butterfly stages.
module fft_scale3
    import fft_pkg::*;
(
    input  smp_t d,
    output smp_t q
);

    logic signed [HW-1:0] re;
    logic signed [HW-1:0] im;
    logic signed [HW-1:0] re_s;
    logic signed [HW-1:0] im_s;

    assign re   = d[SW-1:HW];
    assign im   = d[HW-1:0];
    assign re_s = re >>> 3;
    assign im_s = im >>> 3;
    assign q    = {re_s, im_s};

endmodule

// File: rtl/fft8_in_buf.sv
// Serial-to-parallel frame buffer feeding the 8-point FFT core.
// Define FFT8_IN_SCALE_EN to pre-scale samples by 1/8 via fft_scale3.
module fft8_in_buf
    import fft_pkg::*;
(
    input  logic        ck,
    input  logic        rst_n,
    fft8_in_buf_if.slave s,
    output smp_t        xo_000,
    output smp_t        xo_001,
    output smp_t        xo_002,
    output smp_t        xo_003,
    output smp_t        xo_004,
    output smp_t        xo_005,
    output smp_t        xo_006,
    output smp_t        xo_007,
    output logic        xo_valid,
    input  logic        xo_ready,
    output logic        drop,
    output logic [15:0] frm_cnt
);

    st_t           st;
    st_t           st_nxt;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] idx_nxt;
    logic [IW-1:0] slot;
    smp_t          din;
    smp_t          bank [NPT];
    smp_t          xo   [NPT];
    logic          acc;
    logic          free;
    logic          bank_we;
    logic          ld_fill;
    logic          ld_hold;
    logic          drop_nxt;

`ifdef FFT8_IN_SCALE_EN
    fft_scale3 u_scale (
        .d (s.s_data),
        .q (din)
    );
`else
    assign din = s.s_data;
`endif

    assign s.s_ready = rst_n && (st == FILL);
    assign acc       = s.s_valid && s.s_ready;
    assign free      = !xo_valid || xo_ready;
    // sof restarts the frame at slot 0 regardless of fill level
    assign slot      = s.s_sof ? '0 : wr_idx;

    always_comb begin
        st_nxt   = st;
        idx_nxt  = wr_idx;
        bank_we  = 1'b0;
        ld_fill  = 1'b0;
        ld_hold  = 1'b0;
        drop_nxt = 1'b0;
        unique case (st)
            FILL: begin
                if (acc) begin
                    bank_we  = 1'b1;
                    drop_nxt = s.s_sof && (wr_idx != '0);
                    idx_nxt  = slot + IW'(1);
                    if (slot == IW'(NPT-1)) begin
                        if (free) ld_fill = 1'b1;
                        else      st_nxt  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (xo_valid && xo_ready) begin
                    ld_hold = 1'b1;
                    st_nxt  = FILL;
                    idx_nxt = '0;
                end
            end
        endcase
    end

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            st       <= FILL;
            wr_idx   <= '0;
            xo_valid <= 1'b0;
            drop     <= 1'b0;
            frm_cnt  <= '0;
            for (int i = 0; i < NPT; i++) xo[i] <= '0;
        end else begin
            st     <= st_nxt;
            wr_idx <= idx_nxt;
            drop   <= drop_nxt;
            if (ld_fill || ld_hold) begin
                xo_valid <= 1'b1;
                frm_cnt  <= frm_cnt + 16'd1;
            end else if (xo_ready) begin
                xo_valid <= 1'b0;
            end
            // last sample bypasses the bank when the slot is free
            if (ld_fill) begin
                for (int i = 0; i < NPT-1; i++) xo[i] <= bank[i];
                xo[NPT-1] <= din;
            end else if (ld_hold) begin
                for (int i = 0; i < NPT; i++) xo[i] <= bank[i];
            end
        end
    end

    always_ff @(posedge ck) begin
        if (bank_we) bank[slot] <= din;
    end

    assign xo_000 = xo[0];
    assign xo_001 = xo[1];
    assign xo_002 = xo[2];
    assign xo_003 = xo[3];
    assign xo_004 = xo[4];
    assign xo_005 = xo[5];
    assign xo_006 = xo[6];
    assign xo_007 = xo[7];

endmodule

// File: tb/tb_fft8_in_buf.sv
// Self-checking bench for fft8_in_buf: vector table, corner sequences,
// and random traffic against a frame-level queue model.
module tb_fft8_in_buf;
    import fft_pkg::*;

    logic        ck = 1'b0;
    logic        rst_n = 1'b0;
    logic        xo_ready = 1'b0;
    smp_t        xo_000, xo_001, xo_002, xo_003;
    smp_t        xo_004, xo_005, xo_006, xo_007;
    logic        xo_valid;
    logic        drop;
    logic [15:0] frm_cnt;
    smp_t        xo_w [8];

    fft8_in_buf_if sif ();

    fft8_in_buf dut (
        .ck       (ck),
        .rst_n    (rst_n),
        .s        (sif.slave),
        .xo_000   (xo_000),
        .xo_001   (xo_001),
        .xo_002   (xo_002),
        .xo_003   (xo_003),
        .xo_004   (xo_004),
        .xo_005   (xo_005),
        .xo_006   (xo_006),
        .xo_007   (xo_007),
        .xo_valid (xo_valid),
        .xo_ready (xo_ready),
        .drop     (drop),
        .frm_cnt  (frm_cnt)
    );

    always #5 ck = ~ck;

    assign xo_w[0] = xo_000;
    assign xo_w[1] = xo_001;
    assign xo_w[2] = xo_002;
    assign xo_w[3] = xo_003;
    assign xo_w[4] = xo_004;
    assign xo_w[5] = xo_005;
    assign xo_w[6] = xo_006;
    assign xo_w[7] = xo_007;

    int n_run = 0;
    int n_fail = 0;

    // frame-level model: partial frame queue, one held frame, one output frame
    smp_t        m_q [$];
    smp_t        m_pend [8];
    bit          m_pv;
    smp_t        m_out [8];
    bit          m_ov;
    bit          m_drop;
    logic [15:0] m_cnt;

    function automatic smp_t scl(smp_t d);
        logic signed [15:0] r;
        logic signed [15:0] i;
        r = d[31:16];
        i = d[15:0];
`ifdef FFT8_IN_SCALE_EN
        return {r >>> 3, i >>> 3};
`else
        return {r, i};
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_step(input bit v, input bit sof,
                              input smp_t d, input bit xr);
        bit   cons;
        bit   ld;
        smp_t f [8];
        if (!rst_n) begin
            m_q.delete();
            m_pv   = 0;
            m_ov   = 0;
            m_drop = 0;
            m_cnt  = '0;
            for (int i = 0; i < 8; i++) m_out[i] = '0;
            return;
        end
        cons   = m_ov && xr;
        ld     = 0;
        m_drop = 0;
        if (m_pv) begin
            if (cons) begin
                m_out = m_pend;
                m_pv  = 0;
                ld    = 1;
            end
        end else if (v) begin
            if (sof) begin
                m_drop = (m_q.size() != 0);
                m_q.delete();
            end
            m_q.push_back(scl(d));
            if (m_q.size() == 8) begin
                for (int i = 0; i < 8; i++) f[i] = m_q[i];
                m_q.delete();
                if (!m_ov || cons) begin
                    m_out = f;
                    ld    = 1;
                end else begin
                    m_pend = f;
                    m_pv   = 1;
                end
            end
        end
        if (ld) begin
            m_ov  = 1;
            m_cnt = m_cnt + 16'd1;
        end else if (cons) begin
            m_ov = 0;
        end
    endtask

    task automatic check_all();
        chk("s_ready", 32'(sif.s_ready), 32'(rst_n && !m_pv));
        chk("xo_valid", 32'(xo_valid), 32'(m_ov));
        chk("drop", 32'(drop), 32'(m_drop));
        chk("frm_cnt", 32'(frm_cnt), 32'(m_cnt));
        for (int i = 0; i < 8; i++)
            chk($sformatf("xo_%03d", i), xo_w[i], m_out[i]);
    endtask

    task automatic step(input bit v, input bit sof,
                        input smp_t d, input bit xr);
        sif.s_valid = v;
        sif.s_sof   = sof;
        sif.s_data  = d;
        xo_ready    = xr;
        @(posedge ck);
        model_step(v, sof, d, xr);
        #1;
        check_all();
    endtask

    typedef struct {
        bit          v;
        bit          sof;
        logic [31:0] d;
        bit          xr;
        bit          e_valid;
        bit          e_ready;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t        tbl [9];
    logic [31:0] smp [8];
    smp_t        f1 [8];
    smp_t        f2 [8];
    smp_t        sof_smp;
    int          ndrop;

    initial begin
        smp[0] = 32'h0000_0000; smp[1] = 32'h075A_0000;
        smp[2] = 32'h0A66_0000; smp[3] = 32'h075A_0000;
        smp[4] = 32'h0000_0000; smp[5] = 32'hF8A6_0000;
        smp[6] = 32'hF59A_0000; smp[7] = 32'hF8A6_0000;
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, i == 0, smp[i], 1'b1, i == 7, 1'b1,
                       (i == 7) ? 16'd1 : 16'd0};
        tbl[8] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 16'd1};

        sif.s_valid = 0;
        sif.s_sof   = 0;
        sif.s_data  = '0;

        // reset held two cycles
        rst_n = 0;
        step(0, 0, '0, 0);
        step(0, 0, '0, 0);
        chk("rst_valid", 32'(xo_valid), 32'd0);
        chk("rst_ready", 32'(sif.s_ready), 32'd0);
        chk("rst_cnt", 32'(frm_cnt), 32'd0);
        rst_n = 1;
        step(0, 0, '0, 0);
        chk("rel_ready", 32'(sif.s_ready), 32'd1);

        // single frame from the table
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].v, tbl[i].sof, tbl[i].d, tbl[i].xr);
            chk("tbl_valid", 32'(xo_valid), 32'(tbl[i].e_valid));
            chk("tbl_ready", 32'(sif.s_ready), 32'(tbl[i].e_ready));
            chk("tbl_cnt", 32'(frm_cnt), 32'(tbl[i].e_cnt));
            if (i == 7)
                for (int k = 0; k < 8; k++)
                    chk("tbl_frame", xo_w[k], scl(smp[k]));
        end

        // backpressure: second frame goes to HOLD
        for (int i = 0; i < 8; i++) begin
            f1[i] = $urandom;
            f2[i] = $urandom;
        end
        for (int i = 0; i < 8; i++) step(1, i == 0, f1[i], 0);
        for (int i = 0; i < 8; i++) step(1, i == 0, f2[i], 0);
        chk("bp_ready", 32'(sif.s_ready), 32'd0);
        chk("bp_held", xo_000, scl(f1[0]));
        step(1, 0, 32'h1234_5678, 0);
        chk("bp_stable", xo_007, scl(f1[7]));
        step(0, 0, '0, 1);
        chk("bp_second", xo_000, scl(f2[0]));
        chk("bp_ready_back", 32'(sif.s_ready), 32'd1);
        chk("bp_valid", 32'(xo_valid), 32'd1);
        step(0, 0, '0, 1);
        chk("bp_drain", 32'(xo_valid), 32'd0);

        // resync: sof after 3 samples
        ndrop = 0;
        sof_smp = $urandom;
        for (int i = 0; i < 3; i++) begin
            step(1, i == 0, $urandom, 1);
            if (drop) ndrop++;
        end
        step(1, 1, sof_smp, 1);
        if (drop) ndrop++;
        for (int i = 0; i < 7; i++) begin
            step(1, 0, $urandom, 1);
            if (drop) ndrop++;
        end
        chk("resync_drops", 32'(ndrop), 32'd1);
        chk("resync_xo0", xo_000, scl(sof_smp));
        chk("resync_valid", 32'(xo_valid), 32'd1);

        // scaler corner value
        for (int i = 0; i < 8; i++) step(1, i == 0, 32'h0A66_F59A, 1);
`ifdef FFT8_IN_SCALE_EN
        chk("scale_word", xo_003, 32'h014C_FEB3);
`else
        chk("scale_word", xo_003, 32'h0A66_F59A);
`endif

        // counter wrap via preload
        step(0, 0, '0, 1);
        force dut.frm_cnt = 16'hFFFF;
        #1;
        release dut.frm_cnt;
        m_cnt = 16'hFFFF;
        chk("wrap_pre", 32'(frm_cnt), 32'h0000_FFFF);
        for (int i = 0; i < 8; i++) step(1, i == 0, $urandom, 1);
        chk("wrap_post", 32'(frm_cnt), 32'd0);

        // random traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) rst_n = 0;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                 $urandom, $urandom_range(0, 2) != 0);
            rst_n = 1;
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
